// File: rtl/produttore_media_pkg.sv
// Shared types and defaults for the averaging soc/eoc producer.
// State encoding and the accumulator width live here.
package produttore_media_pkg;

  localparam int W_DEF      = 8;
  localparam int LOG2_N_DEF = 2;
  localparam int ACC_W_DEF  = W_DEF + LOG2_N_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    FINE = 2'd2
  } star_t;

endpackage

// File: rtl/produttore_media_if.sv
// soc/eoc 4-phase bundle between the producer and its consumer.
// The producer side is the slave modport: it receives soc and x.
interface produttore_media_if #(
  parameter int W = 8
);

  logic         soc;
  logic [W-1:0] x;
  logic         eoc;
  logic [W-1:0] numero;

  modport master (
    output soc,
    output x,
    input  eoc,
    input  numero
  );

  modport slave (
    input  soc,
    input  x,
    output eoc,
    output numero
  );

endinterface

// File: rtl/produttore_media.sv
// Averages N_SAMPLES consecutive x samples per soc request and
// returns a nonzero result through a full 4-phase soc/eoc handshake.
module produttore_media
  import produttore_media_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int LOG2_N    = LOG2_N_DEF,
  parameter int N_SAMPLES = 1 << LOG2_N,
  parameter int ZERO_SUB  = 1
) (
  input  logic             clock,
  input  logic             reset,
  produttore_media_if.slave bus
);

  localparam int AW = W + LOG2_N;
  localparam int CW = LOG2_N + 1;

  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);
  localparam logic [W-1:0]  SUB  = W'(ZERO_SUB);

  star_t         r_star;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_eoc;
  logic [W-1:0]  r_numero;

  logic [AW-1:0] w_x_ext;
  logic [W-1:0]  w_avg;
  logic [W-1:0]  w_res;

  assign w_x_ext = {{LOG2_N{1'b0}}, bus.x};
  assign w_avg   = r_acc[AW-1:LOG2_N];
  assign w_res   = (w_avg == '0) ? SUB : w_avg;

  assign bus.eoc    = r_eoc;
  assign bus.numero = r_numero;

  // numero only moves on the edge that raises eoc
  always_ff @(posedge clock) begin
    if (reset) begin
      r_star   <= IDLE;
      r_eoc    <= 1'b1;
      r_numero <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_star)
        IDLE: begin
          r_eoc <= 1'b1;
          if (bus.soc) begin
            r_eoc  <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_star <= ACQ;
          end
        end
        ACQ: begin
          r_eoc <= 1'b0;
          r_acc <= r_acc + w_x_ext;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_star <= FINE;
        end
        FINE: begin
          if (!bus.soc) begin
            r_numero <= w_res;
            r_eoc    <= 1'b1;
            r_star   <= IDLE;
          end else begin
            r_eoc <= 1'b0;
          end
        end
        default: begin
          r_eoc  <= 1'b1;
          r_star <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_produttore_media.sv
// Randomized scoreboard bench for produttore_media.
// Stimulus queues expected averages; a monitor checks them at eoc rise.
module tb_produttore_media;

  logic clock = 1'b0;
  logic reset = 1'b1;

  produttore_media_if #(.W(8)) bus ();

  produttore_media #(
    .W(8),
    .LOG2_N(2),
    .N_SAMPLES(4),
    .ZERO_SUB(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_num = 8'd0;
  logic       prev_eoc = 1'b1;
  logic [7:0] want_v;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t",
               name, got, want, $time);
    end
  endtask

  // Reference: floor of the mean, zero replaced by 1
  function automatic logic [7:0] model(input int s[4]);
    int sum;
    int avg;
    sum = s[0] + s[1] + s[2] + s[3];
    avg = sum / 4;
    return (avg == 0) ? 8'd1 : 8'(avg);
  endfunction

  always @(posedge clock) begin
    #1;
    if (reset) begin
      chk("reset_eoc", 32'(bus.eoc), 32'd1);
      chk("reset_numero", 32'(bus.numero), 32'd0);
      exp_q.delete();
      last_num = 8'd0;
      prev_eoc = 1'b1;
    end else begin
      if (bus.eoc && !prev_eoc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d required none at %0t",
                   bus.numero, $time);
        end else begin
          want_v = exp_q.pop_front();
          chk("numero", 32'(bus.numero), 32'(want_v));
          last_num = want_v;
        end
      end else begin
        chk("numero_hold", 32'(bus.numero), 32'(last_num));
      end
      prev_eoc = bus.eoc;
    end
  end

  // Called at a negedge; soc is high on edges e0..e_h
  task automatic convert(input int xs[4], input int h);
    int rise;
    rise = (h + 1 > 5) ? h + 1 : 5;
    bus.soc = 1'b1;
    bus.x   = 8'($urandom);
    for (int k = 1; k <= rise; k++) begin
      @(negedge clock);
      chk("eoc_busy", 32'(bus.eoc), 32'd0);
      if (k <= 4) bus.x = 8'(xs[k-1]);
      else        bus.x = 8'($urandom);
      bus.soc = (k <= h);
      if (k == 4) exp_q.push_back(model(xs));
    end
    @(negedge clock);
    chk("eoc_done", 32'(bus.eoc), 32'd1);
    bus.soc = 1'b0;
  endtask

  task automatic reset_mid_acq();
    bus.soc = 1'b1;
    bus.x   = 8'($urandom);
    @(negedge clock);
    chk("eoc_busy_r", 32'(bus.eoc), 32'd0);
    bus.soc = 1'b0;
    bus.x   = 8'd200;
    @(negedge clock);
    bus.x   = 8'd200;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset_eoc", 32'(bus.eoc), 32'd1);
    chk("mid_reset_numero", 32'(bus.numero), 32'd0);
    reset = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.soc = 1'b0;
    repeat (n) begin
      @(negedge clock);
      bus.x = 8'($urandom);
    end
  endtask

  initial begin
    int xs[4];
    int hh;
    bus.soc = 1'b0;
    bus.x   = 8'd0;
    repeat (2) @(negedge clock);
    chk("init_eoc", 32'(bus.eoc), 32'd1);
    chk("init_numero", 32'(bus.numero), 32'd0);
    reset = 1'b0;
    gap(1);

    xs = '{10, 10, 10, 10};    convert(xs, 0);
    xs = '{1, 2, 3, 4};        convert(xs, 0);
    xs = '{255, 255, 255, 255}; convert(xs, 0);
    xs = '{0, 0, 0, 0};        convert(xs, 0);
    xs = '{1, 1, 1, 0};        convert(xs, 0);
    xs = '{100, 50, 20, 9};    convert(xs, 7);
    gap(2);
    reset_mid_acq();
    xs = '{8, 8, 8, 8};        convert(xs, 0);
    xs = '{3, 3, 3, 3};        convert(xs, 2);
    xs = '{6, 6, 6, 6};        convert(xs, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (n % 4 == 0) xs[i] = int'($urandom_range(0, 3));
        else            xs[i] = int'($urandom_range(0, 255));
      end
      hh = int'($urandom_range(0, 7));
      convert(xs, hh);
      gap(int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
